atbs_core_board: RTL and testbench
==================================

Name: atbs_core_board

Overview:
- Digital core of a fixed-window adaptive threshold-based sampling (ATBS) ADC front end.
- Keeps an upper and a lower threshold DAC code around a moving centre. It strobes the window comparators and shifts the window by delta when the input leaves it (TBS), or by a growing delta (ATBS).
- Also generates the analog control signals, the non-overlapping clocks and the status LEDs.

Parameters:
- DAC_BITWIDTH, 4: threshold DAC code width N.
- DAC_SETTLING_CLKS, 10: settle wait after each evaluation.
- DEBOUNCE_CLKS, 16: stable clocks required to accept a switch level.
- NOC_DIV, 8: non-overlapping clock period in clocks.
- CAP_SEL, 3'b100: amplifier gain capacitor code.

Ports:
- clock_i  in  1  system clock (8 MHz)
- reset_n_i  in  1  async active-low reset
- comp_upper_i  in  1  1 = input above upper threshold
- comp_lower_i  in  1  1 = input above lower threshold
- trigger_start_sampling_i  in  1  external start trigger
- trigger_start_mode_i  in  1  0 = start directly, 1 = start on trigger rising edge
- adaptive_mode_i  in  1  0 = TBS, 1 = ATBS
- control_mode_i  in  1  reserved, ignored
- signal_select_in_i  in  1  input select (0 = ECG, 1 = BNC)
- enable_i  in  1  global enable
- select_tbs_delta_steps_i  in  1  0 = delta 1, 1 = delta 2^(N-3)
- phi_comp_o  out  1  comparator strobe
- phi_dac_upper_o / phi_dac_lower_o  out  1  DAC load strobes
- dac_upper_o / dac_lower_o  out  N  threshold codes
- phi_vcm_generator_1_o/_2_o, phi_bias_1_o/_2_o, phi_cmfb_1_o/_2_o, phi_res_1_o/_2_o  out  1  two-phase clocks
- bio_amp_en_o  out  1  amplifier enable
- select_cap_o  out  3  gain select
- select_spdt_o  out  1  SPDT input switch
- idle_led_o, overflow_led_o, underflow_led_o  out  1  status
- spike_o  out  1  crossing-event pulse
- uart_rx_i  in  1  reserved, ignored
- uart_tx_o  out  1  serial event output, idle high

Behaviour:
- Reset values: state IDLE, centre c = 2^(N-1), dac_upper_o = c+1, dac_lower_o = c-1, uart_tx_o = 1, all other outputs 0.
- Conditioning:
  - All switch and trigger inputs use a 2-FF synchroniser.
  - Switches are then debounced: the new level is accepted after DEBOUNCE_CLKS identical samples.
  - Comparator inputs are 2-FF synchronised only.
- FSM, IDLE:
  - idle_led_o = 1.
  - Leave IDLE when enable = 1 and either trigger_start_mode = 0 or a trigger rising edge occurs.
- FSM, STARTUP:
  - Load c = 2^(N-1); clear both LEDs and the ATBS delta.
  - phi_res_1 = 1 for DAC_SETTLING_CLKS clocks, then go to COMP.
- FSM, COMP: phi_comp_o = 1 for 1 clock.
- FSM, EVAL: one evaluation per loop.
  - comp_upper = 1 → up event; this takes priority if both conditions are true.
  - Else comp_lower = 0 → down event.
  - Else no event; reset the ATBS delta to base.
- FSM, SETTLE: wait DAC_SETTLING_CLKS clocks, then COMP. Loop period = DAC_SETTLING_CLKS + 2 clocks.
- Events:
  - Up event: c += delta.
  - Down event: c -= delta.
  - c is clamped to [1, 2^N-2]. Clamping sets overflow_led_o (up) or underflow_led_o (down). LEDs are sticky until STARTUP.
  - On the clock after EVAL: codes are updated, phi_dac_upper_o and phi_dac_lower_o pulse for 1 clock, and spike_o pulses for 1 clock.
- Delta:
  - TBS: delta = 1, or 2^(N-3) when select_tbs_delta_steps = 1.
  - ATBS: delta starts at 1. It doubles on each consecutive same-direction event, saturating at 2^(N-2). It resets to 1 on a direction change or a no-event evaluation.
- enable deasserting in any state → IDLE next clock; codes return to reset values.
- Mode switches take effect at the next EVAL.
- Non-overlapping clocks:
  - A counter runs modulo NOC_DIV while enable = 1; outputs are 0 when disabled.
  - _1 outputs are high at counts 0..NOC_DIV/2-2; _2 outputs are high at counts NOC_DIV/2..NOC_DIV-2. Each phase is followed by one dead clock.
  - vcm, bias and cmfb pairs are identical.
  - phi_res pair: phi_res_1 is active only in STARTUP; phi_res_2 is always 0.
- Static outputs: bio_amp_en_o = debounced enable; select_cap_o = CAP_SEL when enabled, else 0; select_spdt_o = debounced signal_select.

Optional Feature:
- ATBS_UART_EN defined:
  - 8N1 UART TX with divider 69 (115200 baud at 8 MHz).
  - Sends one byte per event: {dir (1 = up), log2(delta)[2:0], c[3:0]}.
  - An event arriving while the TX is busy is dropped.
- Undefined: uart_tx_o is held at 1.

Decomposition:
- Package atbs_pkg:
  - FSM state enum (IDLE, STARTUP, COMP, EVAL, SETTLE).
  - Default parameter constants.
  - Delta function (mode, select, count) → step.
- Sub-module atbs_debounce: synchroniser plus debounce, one instance per switch.

Test Plan:
- Reset, all switches 0 except enable = 1, comps 1/0 (in window) → after debounce and STARTUP, phi_comp pulses every 12 clocks; dac_upper = 9, dac_lower = 7; no DAC strobes.
- Hold comp_lower = 0, TBS, full resolution → dac_lower steps 7, 6, …, 0, one step per 12 clocks; then clamps at c = 1 with underflow_led = 1; spike pulses once per step.
- Then comp_upper = 1 → c rises to 14 (dac_upper = 15); overflow_led = 1.
- select_tbs_delta_steps = 1, hold down → c = 8, 6, 4, 2, then clamped at 1.
- ATBS, hold down → c = 8, 7, 5, 1 (delta 1, 2, 4); then comps in window → delta resets to 1.
- Toggle enable 0 for 5 clocks mid-sampling → enable is rejected by debounce; toggle for 20 clocks → IDLE, idle_led = 1, NOCs stop, codes reset to 9/7.

Source files
------------

// File: rtl/atbs_pkg.sv
// Shared types and defaults for the ATBS ADC digital core.
package atbs_pkg;

  localparam int unsigned AtbsDacBitwidth     = 4;
  localparam int unsigned AtbsDacSettlingClks = 10;
  localparam int unsigned AtbsDebounceClks    = 16;
  localparam int unsigned AtbsNocDiv          = 8;
  localparam logic [2:0]  AtbsCapSel          = 3'b100;

  typedef enum logic [2:0] {
    StIdle,
    StStartup,
    StComp,
    StEval,
    StSettle
  } atbs_state_e;

  // Returns log2 of the window step for the current evaluation.
  // In ATBS mode the caller supplies the already-updated streak exponent.
  function automatic logic [2:0] atbs_delta_lg(input logic        adaptive,
                                               input logic        big_steps,
                                               input logic [2:0]  atbs_lg,
                                               input int unsigned n);
    if (adaptive) return atbs_lg;
    if (big_steps) return 3'(n - 3);
    return 3'd0;
  endfunction

endpackage

// File: rtl/atbs_debounce.sv
// Two-flop synchroniser followed by a level debouncer: a new level is
// accepted only after DEBOUNCE_CLKS consecutive identical samples.
module atbs_debounce
  import atbs_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CLKS = AtbsDebounceClks
) (
  input  logic clock_i,
  input  logic reset_n_i,
  input  logic sw_i,
  output logic sw_o
);

  localparam int unsigned CntW = (DEBOUNCE_CLKS > 1) ? $clog2(DEBOUNCE_CLKS) : 1;

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Count samples that disagree with the accepted level; any agreeing sample restarts.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CntW'(DEBOUNCE_CLKS - 1)) level_d = sync2_q;
      else cnt_d = cnt_q + CntW'(1);
    end
  end

  // Synchroniser and debounce state.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sw_o = level_q;

endmodule

// File: rtl/atbs_core_board.sv
// ATBS ADC front-end core: threshold window tracking FSM, non-overlapping
// analog clocks and status outputs. Define ATBS_UART_EN to add an 8N1 event
// transmitter on uart_tx_o; otherwise uart_tx_o idles high.
module atbs_core_board
  import atbs_pkg::*;
#(
  parameter int unsigned DAC_BITWIDTH      = AtbsDacBitwidth,
  parameter int unsigned DAC_SETTLING_CLKS = AtbsDacSettlingClks,
  parameter int unsigned DEBOUNCE_CLKS     = AtbsDebounceClks,
  parameter int unsigned NOC_DIV           = AtbsNocDiv,
  parameter logic [2:0]  CAP_SEL           = AtbsCapSel
) (
  input  logic                    clock_i,
  input  logic                    reset_n_i,
  input  logic                    comp_upper_i,
  input  logic                    comp_lower_i,
  input  logic                    trigger_start_sampling_i,
  input  logic                    trigger_start_mode_i,
  input  logic                    adaptive_mode_i,
  input  logic                    control_mode_i,
  input  logic                    signal_select_in_i,
  input  logic                    enable_i,
  input  logic                    select_tbs_delta_steps_i,
  output logic                    phi_comp_o,
  output logic                    phi_dac_upper_o,
  output logic                    phi_dac_lower_o,
  output logic [DAC_BITWIDTH-1:0] dac_upper_o,
  output logic [DAC_BITWIDTH-1:0] dac_lower_o,
  output logic                    phi_vcm_generator_1_o,
  output logic                    phi_vcm_generator_2_o,
  output logic                    phi_bias_1_o,
  output logic                    phi_bias_2_o,
  output logic                    phi_cmfb_1_o,
  output logic                    phi_cmfb_2_o,
  output logic                    phi_res_1_o,
  output logic                    phi_res_2_o,
  output logic                    bio_amp_en_o,
  output logic [2:0]              select_cap_o,
  output logic                    select_spdt_o,
  output logic                    idle_led_o,
  output logic                    overflow_led_o,
  output logic                    underflow_led_o,
  output logic                    spike_o,
  input  logic                    uart_rx_i,
  output logic                    uart_tx_o
);

  localparam int unsigned N    = DAC_BITWIDTH;
  localparam int unsigned SetW = (DAC_SETTLING_CLKS > 1) ? $clog2(DAC_SETTLING_CLKS) : 1;
  localparam int unsigned NocW = (NOC_DIV > 1) ? $clog2(NOC_DIV) : 1;
  localparam logic [N-1:0] Center = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] One    = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0] CMax   = {{(N-1){1'b1}}, 1'b0};
  localparam logic [2:0]   LgMax  = 3'(N - 2);

  logic en, trig_mode, adaptive, sel_steps, sig_sel;

  atbs_debounce #(.DEBOUNCE_CLKS(DEBOUNCE_CLKS)) u_db_enable (
    .clock_i(clock_i), .reset_n_i(reset_n_i), .sw_i(enable_i), .sw_o(en));
  atbs_debounce #(.DEBOUNCE_CLKS(DEBOUNCE_CLKS)) u_db_trig_mode (
    .clock_i(clock_i), .reset_n_i(reset_n_i), .sw_i(trigger_start_mode_i), .sw_o(trig_mode));
  atbs_debounce #(.DEBOUNCE_CLKS(DEBOUNCE_CLKS)) u_db_adaptive (
    .clock_i(clock_i), .reset_n_i(reset_n_i), .sw_i(adaptive_mode_i), .sw_o(adaptive));
  atbs_debounce #(.DEBOUNCE_CLKS(DEBOUNCE_CLKS)) u_db_sel_steps (
    .clock_i(clock_i), .reset_n_i(reset_n_i), .sw_i(select_tbs_delta_steps_i),
    .sw_o(sel_steps));
  atbs_debounce #(.DEBOUNCE_CLKS(DEBOUNCE_CLKS)) u_db_sig_sel (
    .clock_i(clock_i), .reset_n_i(reset_n_i), .sw_i(signal_select_in_i), .sw_o(sig_sel));

  logic comp_up_s1_q, comp_up_q, comp_lo_s1_q, comp_lo_q;
  logic trig_s1_q, trig_s2_q, trig_prev_q;
  logic trig_rise;

  // Comparator and trigger synchronisers plus trigger edge history.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      comp_up_s1_q <= 1'b0;
      comp_up_q    <= 1'b0;
      comp_lo_s1_q <= 1'b0;
      comp_lo_q    <= 1'b0;
      trig_s1_q    <= 1'b0;
      trig_s2_q    <= 1'b0;
      trig_prev_q  <= 1'b0;
    end else begin
      comp_up_s1_q <= comp_upper_i;
      comp_up_q    <= comp_up_s1_q;
      comp_lo_s1_q <= comp_lower_i;
      comp_lo_q    <= comp_lo_s1_q;
      trig_s1_q    <= trigger_start_sampling_i;
      trig_s2_q    <= trig_s1_q;
      trig_prev_q  <= trig_s2_q;
    end
  end

  assign trig_rise = trig_s2_q & ~trig_prev_q;

  atbs_state_e     state_q, state_d;
  logic [SetW-1:0] cnt_q, cnt_d;
  logic [N-1:0]    c_q, c_d;
  logic            ovf_q, ovf_d, unf_q, unf_d;
  logic [2:0]      lg_q, lg_d, lg_new, step_lg;
  logic            streak_q, streak_d, dir_q, dir_d;
  logic            dac_stb_q, dac_stb_d, spike_q, spike_d, idle_led_q;
  logic            ev_valid, ev_up;
  logic [N:0]      step, sum;

  // Sequencer: window evaluation, clamping and adaptive step tracking.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    c_d       = c_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    lg_d      = lg_q;
    streak_d  = streak_q;
    dir_d     = dir_q;
    dac_stb_d = 1'b0;
    spike_d   = 1'b0;
    ev_valid  = 1'b0;
    ev_up     = 1'b0;
    lg_new    = '0;
    step_lg   = '0;
    step      = '0;
    sum       = '0;
    unique case (state_q)
      StIdle: begin
        if (en && (!trig_mode || trig_rise)) begin
          state_d = StStartup;
          cnt_d   = '0;
        end
      end
      StStartup: begin
        c_d      = Center;
        ovf_d    = 1'b0;
        unf_d    = 1'b0;
        lg_d     = '0;
        streak_d = 1'b0;
        if (cnt_q == SetW'(DAC_SETTLING_CLKS - 1)) begin
          state_d = StComp;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + SetW'(1);
        end
      end
      StComp: state_d = StEval;
      StEval: begin
        state_d = StSettle;
        cnt_d   = '0;
        if (comp_up_q || !comp_lo_q) begin
          ev_valid = 1'b1;
          ev_up    = comp_up_q;
          // A streak only grows on back-to-back events in the same direction.
          if (adaptive && streak_q && (dir_q == ev_up)) begin
            lg_new = (lg_q == LgMax) ? lg_q : lg_q + 3'd1;
          end
          step_lg = atbs_delta_lg(adaptive, sel_steps, lg_new, N);
          step    = {{N{1'b0}}, 1'b1} << step_lg;
          if (ev_up) begin
            sum = {1'b0, c_q} + step;
            if (sum > {1'b0, CMax}) begin
              c_d   = CMax;
              ovf_d = 1'b1;
            end else begin
              c_d = sum[N-1:0];
            end
          end else if ({1'b0, c_q} <= step) begin
            c_d   = One;
            unf_d = 1'b1;
          end else begin
            c_d = c_q - step[N-1:0];
          end
          lg_d      = lg_new;
          streak_d  = adaptive;
          dir_d     = ev_up;
          dac_stb_d = 1'b1;
          spike_d   = 1'b1;
        end else begin
          lg_d     = '0;
          streak_d = 1'b0;
        end
      end
      StSettle: begin
        if (cnt_q == SetW'(DAC_SETTLING_CLKS - 1)) begin
          state_d = StComp;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + SetW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    // Losing enable aborts from anywhere and restores the idle codes.
    if (!en) begin
      state_d   = StIdle;
      cnt_d     = '0;
      c_d       = Center;
      dac_stb_d = 1'b0;
      spike_d   = 1'b0;
      ev_valid  = 1'b0;
    end
  end

  // Sequencer state.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      c_q        <= Center;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      lg_q       <= '0;
      streak_q   <= 1'b0;
      dir_q      <= 1'b0;
      dac_stb_q  <= 1'b0;
      spike_q    <= 1'b0;
      idle_led_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      c_q        <= c_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      lg_q       <= lg_d;
      streak_q   <= streak_d;
      dir_q      <= dir_d;
      dac_stb_q  <= dac_stb_d;
      spike_q    <= spike_d;
      idle_led_q <= (state_d == StIdle);
    end
  end

  logic [NocW-1:0] noc_q, noc_d;
  logic            noc_1, noc_2;

  // Non-overlapping clock phase counter, parked at zero while disabled.
  always_comb begin
    noc_d = '0;
    if (en) noc_d = (noc_q == NocW'(NOC_DIV - 1)) ? '0 : noc_q + NocW'(1);
  end

  // Phase counter register.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) noc_q <= '0;
    else noc_q <= noc_d;
  end

  assign noc_1 = en && (noc_q <= NocW'(NOC_DIV / 2 - 2));
  assign noc_2 = en && (noc_q >= NocW'(NOC_DIV / 2)) && (noc_q <= NocW'(NOC_DIV - 2));

  assign phi_vcm_generator_1_o = noc_1;
  assign phi_vcm_generator_2_o = noc_2;
  assign phi_bias_1_o          = noc_1;
  assign phi_bias_2_o          = noc_2;
  assign phi_cmfb_1_o          = noc_1;
  assign phi_cmfb_2_o          = noc_2;
  assign phi_res_1_o           = (state_q == StStartup);
  assign phi_res_2_o           = 1'b0;

  assign phi_comp_o      = (state_q == StComp);
  assign phi_dac_upper_o = dac_stb_q;
  assign phi_dac_lower_o = dac_stb_q;
  assign dac_upper_o     = c_q + One;
  assign dac_lower_o     = c_q - One;
  assign spike_o         = spike_q;
  assign idle_led_o      = idle_led_q;
  assign overflow_led_o  = ovf_q;
  assign underflow_led_o = unf_q;
  assign bio_amp_en_o    = en;
  assign select_cap_o    = en ? CAP_SEL : 3'b000;
  assign select_spdt_o   = sig_sel;

`ifdef ATBS_UART_EN
  localparam int unsigned UartDiv = 69;

  logic [9:0] tx_sh_q, tx_sh_d;
  logic [6:0] baud_q, baud_d;
  logic [3:0] bits_q, bits_d;
  logic       busy_q, busy_d;
  logic [3:0] c_nib;
  logic       unused_in;

  assign c_nib     = 4'(c_d);
  assign unused_in = ^{uart_rx_i, control_mode_i};

  // 8N1 framer, LSB first; events arriving while busy are dropped.
  always_comb begin
    tx_sh_d = tx_sh_q;
    baud_d  = baud_q;
    bits_d  = bits_q;
    busy_d  = busy_q;
    if (busy_q) begin
      if (baud_q == 7'(UartDiv - 1)) begin
        baud_d  = '0;
        tx_sh_d = {1'b1, tx_sh_q[9:1]};
        if (bits_q == 4'd9) busy_d = 1'b0;
        else bits_d = bits_q + 4'd1;
      end else begin
        baud_d = baud_q + 7'd1;
      end
    end else if (ev_valid) begin
      busy_d  = 1'b1;
      baud_d  = '0;
      bits_d  = '0;
      tx_sh_d = {1'b1, ev_up, step_lg, c_nib, 1'b0};
    end
  end

  // UART transmitter state.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      tx_sh_q <= '1;
      baud_q  <= '0;
      bits_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      tx_sh_q <= tx_sh_d;
      baud_q  <= baud_d;
      bits_q  <= bits_d;
      busy_q  <= busy_d;
    end
  end

  assign uart_tx_o = tx_sh_q[0];
`else
  logic unused_in;
  assign unused_in = ^{uart_rx_i, control_mode_i, ev_valid};
  assign uart_tx_o = 1'b1;
`endif

endmodule

// File: tb/tb_atbs_core_board.sv
// Directed bench for atbs_core_board: window tracking in TBS and ATBS modes,
// clamping, enable debounce and the non-overlapping clock pattern.
module tb_atbs_core_board;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       comp_upper, comp_lower, trig, trig_mode, adaptive, ctrl_mode;
  logic       sig_sel, enable, sel_steps, uart_rx;
  logic       phi_comp_o, phi_dac_upper_o, phi_dac_lower_o;
  logic [3:0] dac_upper_o, dac_lower_o;
  logic       vcm_1, vcm_2, bias_1, bias_2, cmfb_1, cmfb_2, res_1, res_2;
  logic       bio_amp_en_o, select_spdt_o, idle_led_o, overflow_led_o, underflow_led_o;
  logic       spike_o, uart_tx_o;
  logic [2:0] select_cap_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  atbs_core_board u_dut (
    .clock_i                  (clk),
    .reset_n_i                (rst_n),
    .comp_upper_i             (comp_upper),
    .comp_lower_i             (comp_lower),
    .trigger_start_sampling_i (trig),
    .trigger_start_mode_i     (trig_mode),
    .adaptive_mode_i          (adaptive),
    .control_mode_i           (ctrl_mode),
    .signal_select_in_i       (sig_sel),
    .enable_i                 (enable),
    .select_tbs_delta_steps_i (sel_steps),
    .phi_comp_o               (phi_comp_o),
    .phi_dac_upper_o          (phi_dac_upper_o),
    .phi_dac_lower_o          (phi_dac_lower_o),
    .dac_upper_o              (dac_upper_o),
    .dac_lower_o              (dac_lower_o),
    .phi_vcm_generator_1_o    (vcm_1),
    .phi_vcm_generator_2_o    (vcm_2),
    .phi_bias_1_o             (bias_1),
    .phi_bias_2_o             (bias_2),
    .phi_cmfb_1_o             (cmfb_1),
    .phi_cmfb_2_o             (cmfb_2),
    .phi_res_1_o              (res_1),
    .phi_res_2_o              (res_2),
    .bio_amp_en_o             (bio_amp_en_o),
    .select_cap_o             (select_cap_o),
    .select_spdt_o            (select_spdt_o),
    .idle_led_o               (idle_led_o),
    .overflow_led_o           (overflow_led_o),
    .underflow_led_o          (underflow_led_o),
    .spike_o                  (spike_o),
    .uart_rx_i                (uart_rx),
    .uart_tx_o                (uart_tx_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance to the next comparator strobe, then to the clock after EVAL.
  task automatic step();
    int n;
    n = 0;
    @(negedge clk);
    while (phi_comp_o !== 1'b1 && n < 80) begin
      @(negedge clk);
      n++;
    end
    check_eq("comp_seen", phi_comp_o, 1);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic idle_checks(input string tag);
    int act;
    act = 0;
    check_eq({tag, "_idle_led"}, idle_led_o, 1);
    check_eq({tag, "_dac_up"}, dac_upper_o, 9);
    check_eq({tag, "_dac_lo"}, dac_lower_o, 7);
    check_eq({tag, "_amp_en"}, bio_amp_en_o, 0);
    check_eq({tag, "_cap"}, select_cap_o, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      act += int'(vcm_1) + int'(vcm_2) + int'(phi_comp_o);
    end
    check_eq({tag, "_quiet"}, act, 0);
  endtask

  initial begin
    int n, res_cnt, c1, c2, ovl, diff;
    rst_n = 1'b0;
    {comp_upper, trig, trig_mode, adaptive, ctrl_mode, sig_sel, enable, sel_steps} = '0;
    comp_lower = 1'b1;
    uart_rx    = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_dac_up", dac_upper_o, 9);
    check_eq("rst_dac_lo", dac_lower_o, 7);
    check_eq("rst_uart_tx", uart_tx_o, 1);
    check_eq("rst_idle_led", idle_led_o, 0);
    check_eq("rst_comp", phi_comp_o, 0);
    check_eq("rst_vcm1", vcm_1, 0);
    rst_n  = 1'b1;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("idle_led_on", idle_led_o, 1);

    // Startup: count reset-phase clocks up to the first comparator strobe.
    n = 0;
    res_cnt = 0;
    while (phi_comp_o !== 1'b1 && n < 80) begin
      @(negedge clk);
      res_cnt += int'(res_1);
      n++;
    end
    check_eq("first_comp", phi_comp_o, 1);
    check_eq("res_clks", res_cnt, 10);
    check_eq("run_idle_led", idle_led_o, 0);
    check_eq("run_amp_en", bio_amp_en_o, 1);
    check_eq("run_cap", select_cap_o, 4);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (phi_comp_o !== 1'b1 && n < 40);
    check_eq("loop_period", n, 12);
    @(negedge clk);
    @(negedge clk);
    check_eq("win_dac_up", dac_upper_o, 9);
    check_eq("win_dac_lo", dac_lower_o, 7);
    check_eq("win_no_stb", phi_dac_upper_o, 0);
    check_eq("win_no_spike", spike_o, 0);

    c1 = 0; c2 = 0; ovl = 0; diff = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      c1 += int'(vcm_1);
      c2 += int'(vcm_2);
      ovl += int'(vcm_1 & vcm_2);
      diff += int'((vcm_1 != bias_1) || (vcm_1 != cmfb_1) || (vcm_2 != bias_2) ||
                   (vcm_2 != cmfb_2) || res_2);
    end
    check_eq("noc_ph1", c1, 3);
    check_eq("noc_ph2", c2, 3);
    check_eq("noc_overlap", ovl, 0);
    check_eq("noc_pairs", diff, 0);

    // TBS, delta 1, walk down to the floor.
    step();
    comp_lower = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      check_eq($sformatf("dn1_lo%0d", i), dac_lower_o, 32'(6 - i));
      check_eq($sformatf("dn1_stb%0d", i), phi_dac_lower_o, 1);
      check_eq($sformatf("dn1_spk%0d", i), spike_o, 1);
    end
    check_eq("dn1_unf_before", underflow_led_o, 0);
    step();
    check_eq("dn1_clamp_lo", dac_lower_o, 0);
    check_eq("dn1_clamp_up", dac_upper_o, 2);
    check_eq("dn1_unf", underflow_led_o, 1);
    @(negedge clk);
    check_eq("stb_width", phi_dac_upper_o, 0);
    check_eq("spike_width", spike_o, 0);

    // Upper comparator wins even with lower low: walk up to the ceiling.
    comp_upper = 1'b1;
    for (int i = 0; i < 13; i++) begin
      step();
      check_eq($sformatf("up1_up%0d", i), dac_upper_o, 32'(3 + i));
    end
    check_eq("up1_ovf_before", overflow_led_o, 0);
    step();
    check_eq("up1_clamp_up", dac_upper_o, 15);
    check_eq("up1_ovf", overflow_led_o, 1);
    check_eq("up1_unf_sticky", underflow_led_o, 1);

    // Short enable glitch must be filtered.
    comp_upper = 1'b0;
    comp_lower = 1'b1;
    step();
    enable = 1'b0;
    repeat (5) @(negedge clk);
    enable = 1'b1;
    step();
    check_eq("glitch_amp_en", bio_amp_en_o, 1);
    check_eq("glitch_dac_up", dac_upper_o, 15);

    // Long disable: back to idle; restart with TBS delta 2 going down.
    sel_steps  = 1'b1;
    comp_lower = 1'b0;
    enable     = 1'b0;
    repeat (25) @(negedge clk);
    idle_checks("dis1");
    enable = 1'b1;
    step();
    check_eq("dn2_lo0", dac_lower_o, 5);
    check_eq("dn2_ovf_clr", overflow_led_o, 0);
    check_eq("dn2_unf_clr", underflow_led_o, 0);
    step();
    check_eq("dn2_lo1", dac_lower_o, 3);
    step();
    check_eq("dn2_lo2", dac_lower_o, 1);
    step();
    check_eq("dn2_lo3", dac_lower_o, 0);
    check_eq("dn2_unf", underflow_led_o, 1);

    // ATBS: growing delta downward, reset on no-event and direction change.
    enable    = 1'b0;
    adaptive  = 1'b1;
    sel_steps = 1'b0;
    repeat (25) @(negedge clk);
    enable = 1'b1;
    step();
    check_eq("at_lo0", dac_lower_o, 6);
    step();
    check_eq("at_lo1", dac_lower_o, 4);
    step();
    check_eq("at_lo2", dac_lower_o, 0);
    check_eq("at_unf_before", underflow_led_o, 0);
    step();
    check_eq("at_lo3", dac_lower_o, 0);
    check_eq("at_unf", underflow_led_o, 1);
    comp_lower = 1'b1;
    step();
    check_eq("at_win_spike", spike_o, 0);
    comp_upper = 1'b1;
    step();
    check_eq("at_up0", dac_upper_o, 3);
    step();
    check_eq("at_up1", dac_upper_o, 5);
    step();
    check_eq("at_up2", dac_upper_o, 9);
    step();
    check_eq("at_up3", dac_upper_o, 13);
    comp_upper = 1'b0;
    comp_lower = 1'b0;
    step();
    check_eq("at_rev0", dac_lower_o, 10);
    step();
    check_eq("at_rev1", dac_lower_o, 8);

    enable = 1'b0;
    repeat (25) @(negedge clk);
    idle_checks("dis2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
